// File: rtl/lamp_fpu_sqrt_arbiter_pkg.sv
// Shared types and constants for the LAMP FPU sqrt/invsqrt arbiter slice.
// Packed float is bfloat16: 1 sign, 8 exponent, 7 fraction bits.
package lamp_fpu_sqrt_arbiter_pkg;

  localparam int LAMP_FLOAT_DW   = 16;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;

  // exponent all ones, fraction MSB set: canonical quiet NaN without sign
  localparam logic [LAMP_FLOAT_DW-2:0] QNAN_E_F = 15'h7FC0;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arbState_t;
  typedef enum logic {SQRT_OP_SQRT, SQRT_OP_INVSQRT} sqrtOp_t;

endpackage

// File: rtl/lamp_fpu_sqrt_arbiter_if.sv
// Requester and unit-side signals of the sqrt arbiter.
// slave = arbiter view, master = requesters plus sqrt unit view.
interface lamp_fpu_sqrt_arbiter_if
  import lamp_fpu_sqrt_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW    = LAMP_FLOAT_DW
) ();
  logic [N_REQ-1:0]         req_valid_i;
  logic [N_REQ-1:0]         req_ready_o;
  logic [N_REQ-1:0]         req_op_i;
  logic [N_REQ-1:0][DW-1:0] req_operand_i;
  logic [N_REQ-1:0]         resp_valid_o;
  logic [N_REQ-1:0]         resp_ready_i;
  logic [DW-1:0]            resp_result_o;
  logic                     resp_err_o;
  logic                     u_doSqrt_o;
  logic                     u_doInvSqrt_o;
  logic [DW-1:0]            u_operand_o;
  logic                     u_valid_i;
  logic [DW-1:0]            u_result_i;

  modport master (
    output req_valid_i, req_op_i, req_operand_i, resp_ready_i, u_valid_i, u_result_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_err_o,
           u_doSqrt_o, u_doInvSqrt_o, u_operand_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_operand_i, resp_ready_i, u_valid_i, u_result_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_err_o,
           u_doSqrt_o, u_doInvSqrt_o, u_operand_o
  );
endinterface

// File: rtl/lamp_fpu_rr_picker.sv
// Combinational round-robin first-one finder: first set request at or after ptr,
// wrapping modulo N. Returns one-hot grant, its index, and whether anything was set.
module lamp_fpu_rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  localparam int SW = IW + 1;

  logic [2*N-1:0] rot;
  logic [IW-1:0]  off;
  logic [SW-1:0]  sum;

  always_comb begin
    // rotate so that bit 0 is the requester at ptr; lowest set bit wins
    rot = {req, req} >> ptr;
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= SW'(N)) ? IW'(sum - SW'(N)) : sum[IW-1:0];
    any = |req;
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/lamp_fpu_sqrt_arbiter.sv
// Round-robin sharing of one iterative sqrt/invsqrt unit among N_REQ requesters,
// one operation in flight. Optional WAIT watchdog: LAMP_SQRT_ARB_TIMEOUT_EN.
module lamp_fpu_sqrt_arbiter
  import lamp_fpu_sqrt_arbiter_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int DW             = LAMP_FLOAT_DW,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  lamp_fpu_sqrt_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : gParamCheck
    $error("lamp_fpu_sqrt_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arbState_t        stateQ, stateD;
  logic [IW-1:0]    ptrQ, ownerQ, pickIdx;
  logic [N_REQ-1:0] pickGnt;
  logic             pickAny, accept, uDone, expire, respHs;
  sqrtOp_t          opQ;
  logic [DW-1:0]    operandQ, resultQ;

  lamp_fpu_rr_picker #(.N(N_REQ), .IW(IW)) picker (
    .req (bus.req_valid_i),
    .ptr (ptrQ),
    .gnt (pickGnt),
    .idx (pickIdx),
    .any (pickAny)
  );

  assign accept = (stateQ == ARB_IDLE) && pickAny;
  assign uDone  = (stateQ == ARB_WAIT) && bus.u_valid_i;
  assign respHs = (stateQ == ARB_RESP) && bus.resp_ready_i[ownerQ];

`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] waitCnt;
  logic          errQ;

  always_ff @(posedge clk) begin
    if (rst)                       waitCnt <= '0;
    else if (stateQ == ARB_ISSUE)  waitCnt <= '0;
    else if (stateQ == ARB_WAIT)   waitCnt <= waitCnt + CW'(1);
  end

  // a result arriving on the expiry cycle takes priority over the watchdog
  assign expire = (stateQ == ARB_WAIT) && !bus.u_valid_i &&
                  (waitCnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)         errQ <= 1'b0;
    else if (uDone)  errQ <= 1'b0;
    else if (expire) errQ <= 1'b1;
  end
  assign bus.resp_err_o = errQ;
`else
  assign expire         = 1'b0;
  assign bus.resp_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) stateQ <= ARB_IDLE;
    else     stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ARB_IDLE:  if (pickAny) stateD = ARB_ISSUE;
      ARB_ISSUE: stateD = ARB_WAIT;
      ARB_WAIT:  if (uDone || expire) stateD = ARB_RESP;
      ARB_RESP:  if (respHs) stateD = ARB_IDLE;
      default:   stateD = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o   = '0;
    bus.resp_valid_o  = '0;
    bus.u_doSqrt_o    = 1'b0;
    bus.u_doInvSqrt_o = 1'b0;
    case (stateQ)
      ARB_IDLE:  bus.req_ready_o = pickGnt;
      ARB_ISSUE: begin
        bus.u_doSqrt_o    = (opQ == SQRT_OP_SQRT);
        bus.u_doInvSqrt_o = (opQ == SQRT_OP_INVSQRT);
      end
      ARB_RESP:  bus.resp_valid_o[ownerQ] = 1'b1;
      default: ;
    endcase
  end

  assign bus.u_operand_o   = operandQ;
  assign bus.resp_result_o = resultQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptrQ     <= '0;
      ownerQ   <= '0;
      opQ      <= SQRT_OP_SQRT;
      operandQ <= '0;
      resultQ  <= '0;
    end else begin
      if (accept) begin
        ownerQ   <= pickIdx;
        opQ      <= sqrtOp_t'(bus.req_op_i[pickIdx]);
        operandQ <= bus.req_operand_i[pickIdx];
      end
      if (uDone)       resultQ <= bus.u_result_i;
      else if (expire) resultQ <= DW'({1'b0, QNAN_E_F});
      if (respHs)
        ptrQ <= (ownerQ == IW'(N_REQ - 1)) ? '0 : ownerQ + IW'(1);
    end
  end
endmodule

// File: tb/tb_lamp_fpu_sqrt_arbiter.sv
// Bench for lamp_fpu_sqrt_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed bfloat16 results and latencies.
module tb_lamp_fpu_sqrt_arbiter;
  import lamp_fpu_sqrt_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int DW = LAMP_FLOAT_DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lamp_fpu_sqrt_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

  lamp_fpu_sqrt_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // reference square-root unit for the operands used here
  function automatic logic [15:0] unitFn(input logic op, input logic [15:0] x);
    case ({op, x})
      17'h0_4080: return 16'h4000;  // sqrt(4)    = 2
      17'h1_4080: return 16'h3F00;  // 1/sqrt(4)  = 0.5
      17'h0_4180: return 16'h4080;  // sqrt(16)   = 4
      17'h1_4180: return 16'h3E80;  // 1/sqrt(16) = 0.25
      17'h0_3F80: return 16'h3F80;
      17'h1_3F80: return 16'h3F80;
      default:    return 16'h7FFF;
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // sqrt unit: responds unitLat cycles after the start pulse
  int          unitLat = 3;
  bit          unitEn  = 1'b1;
  logic [15:0] unitRes;
  initial begin
    bus.u_valid_i  = 1'b0;
    bus.u_result_i = '0;
    forever begin
      @(negedge clk);
      if (unitEn && !rst && (bus.u_doSqrt_o || bus.u_doInvSqrt_o)) begin
        unitRes = unitFn(bus.u_doInvSqrt_o, bus.u_operand_o);
        repeat (unitLat) @(posedge clk);
        #1 bus.u_valid_i = 1'b1; bus.u_result_i = unitRes;
        @(posedge clk);
        #1 bus.u_valid_i = 1'b0; bus.u_result_i = 16'h0BAD;
      end
    end
  end

  // transaction model: who owns the unit, what it must be doing, what it must return
  int          mPtr, mOwner, mWaitCnt, accCycle, pulseCycle, g;
  bit          mBusy, mIssue, mWait, mHave, postRst;
  logic        mOp, mErr;
  logic [15:0] mOperand, mResult;
  logic [N-1:0] expReady, expRespV, accMask;

  always @(negedge clk) begin
    accMask = '0;
    if (rst) begin
      mPtr = 0; mBusy = 0; mIssue = 0; mWait = 0; mHave = 0; postRst = 1;
    end else begin
      g        = mBusy ? -1 : pick(bus.req_valid_i, mPtr);
      expReady = (g < 0) ? '0 : (N'(1) << g);
      expRespV = mHave ? (N'(1) << mOwner) : '0;
      chk("req_ready", bus.req_ready_o, expReady);
      chk("doSqrt", bus.u_doSqrt_o, mIssue && !mOp);
      chk("doInvSqrt", bus.u_doInvSqrt_o, mIssue && mOp);
      chk("resp_valid", bus.resp_valid_o, expRespV);
      if (mIssue || mWait) chk("u_operand", bus.u_operand_o, mOperand);
      if (mHave) begin
        chk("resp_result", bus.resp_result_o, mResult);
        chk("resp_err", bus.resp_err_o, mErr);
      end
      if (postRst) begin
        chk("rst_operand", bus.u_operand_o, 0);
        chk("rst_result", bus.resp_result_o, 0);
        chk("rst_err", bus.resp_err_o, 0);
        postRst = 0;
      end
      if (bus.u_doSqrt_o || bus.u_doInvSqrt_o) pulseCycle = cyc;

      if (mHave && bus.resp_ready_i[mOwner]) begin
        mHave = 0; mBusy = 0; mPtr = (mOwner + 1) % N;
      end else if (mIssue) begin
        mIssue = 0; mWait = 1; mWaitCnt = 0;
      end else if (mWait) begin
        if (bus.u_valid_i) begin
          mWait = 0; mHave = 1; mResult = unitFn(mOp, mOperand); mErr = 0;
        end else begin
          mWaitCnt++;
`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
          if (mWaitCnt == 64) begin
            mWait = 0; mHave = 1; mResult = 16'h7FC0; mErr = 1;
          end
`endif
        end
      end
      if (g >= 0) begin
        mBusy = 1; mIssue = 1; mOwner = g; accCycle = cyc; accMask = expReady;
        mOp = bus.req_op_i[g]; mOperand = bus.req_operand_i[g];
      end
    end
  end

  // requesters drop valid the cycle after being accepted
  task automatic step();
    @(posedge clk);
    #1 bus.req_valid_i = bus.req_valid_i & ~accMask;
  endtask

  task automatic setReq(input int i, input logic op, input logic [15:0] x);
    bus.req_valid_i[i]   = 1'b1;
    bus.req_op_i[i]      = op;
    bus.req_operand_i[i] = x;
  endtask

  task automatic waitResp(input int limit, output logic [N-1:0] v,
                          output logic [15:0] r, output logic e, output int c);
    v = '0; r = '0; e = 1'b0; c = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      @(negedge clk);
      if (bus.resp_valid_o != '0) begin
        v = bus.resp_valid_o; r = bus.resp_result_o; e = bus.resp_err_o; c = cyc;
        return;
      end
    end
    total++; bad++;
    $display("FAIL resp_wait: no response within %0d cycles", limit);
  endtask

  logic [N-1:0] rv;
  logic [15:0]  rr;
  logic         re;
  int           rc, cntV, cntE;

  initial begin
    bus.req_valid_i   = '0;
    bus.req_op_i      = '0;
    bus.req_operand_i = '0;
    bus.resp_ready_i  = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready", bus.req_ready_o, 0);
    chk("reset resp_valid", bus.resp_valid_o, 0);
    chk("reset do pulses", {bus.u_doSqrt_o, bus.u_doInvSqrt_o}, 0);

    // both requesters at once after reset: 0 then 1
    step(); setReq(0, 1'b0, 16'h4180); setReq(1, 1'b0, 16'h3F80);
    waitResp(50, rv, rr, re, rc);
    chk("simul first owner", rv, 2'b01);
    chk("simul first result", rr, 16'h4080);
    waitResp(50, rv, rr, re, rc);
    chk("simul second owner", rv, 2'b10);
    chk("simul second result", rr, 16'h3F80);

    // single sqrt with latency check (unit L=3)
    step(); setReq(0, 1'b0, 16'h4080);
    waitResp(50, rv, rr, re, rc);
    chk("sqrt owner", rv, 2'b01);
    chk("sqrt result", rr, 16'h4000);
    chk("sqrt err", re, 1'b0);
    chk("sqrt resp latency", rc - accCycle, 5);
    chk("sqrt pulse latency", pulseCycle - accCycle, 1);

    // pointer now at 1: simultaneous requests serve 1 first
    step(); setReq(0, 1'b1, 16'h4180); setReq(1, 1'b0, 16'h4080);
    waitResp(50, rv, rr, re, rc);
    chk("rr first owner", rv, 2'b10);
    chk("rr first result", rr, 16'h4000);
    waitResp(50, rv, rr, re, rc);
    chk("rr second owner", rv, 2'b01);
    chk("rr second result", rr, 16'h3E80);

    // inverse sqrt from requester 1, longer unit latency
    unitLat = 5;
    step(); setReq(1, 1'b1, 16'h4080);
    waitResp(50, rv, rr, re, rc);
    chk("invsqrt owner", rv, 2'b10);
    chk("invsqrt result", rr, 16'h3F00);
    chk("invsqrt resp latency", rc - accCycle, 7);

    // backpressure; non-owner ready must be ignored; second request waits
    unitLat = 2;
    bus.resp_ready_i = 2'b10;
    step(); setReq(0, 1'b0, 16'h3F80);
    waitResp(50, rv, rr, re, rc);
    chk("bp owner", rv, 2'b01);
    setReq(1, 1'b0, 16'h4180);
    for (int i = 0; i < 10; i++) begin
      step(); @(negedge clk);
      chk("bp hold valid", bus.resp_valid_o, 2'b01);
      chk("bp hold result", bus.resp_result_o, 16'h3F80);
      chk("bp req_ready", bus.req_ready_o, 0);
    end
    step(); bus.resp_ready_i = '1;
    waitResp(50, rv, rr, re, rc);
    chk("bp next owner", rv, 2'b10);
    chk("bp next result", rr, 16'h4080);

    // reset mid-WAIT: late unit valid must be ignored
    unitLat = 20;
    step(); setReq(0, 1'b1, 16'h4180);
    repeat (6) step();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst resp_valid", bus.resp_valid_o, 0);
    chk("midrst req_ready", bus.req_ready_o, 0);
    chk("midrst do pulses", {bus.u_doSqrt_o, bus.u_doInvSqrt_o}, 0);
    chk("midrst operand", bus.u_operand_o, 0);
    chk("midrst result", bus.resp_result_o, 0);
    cntV = 0;
    for (int i = 0; i < 30; i++) begin
      step(); @(negedge clk);
      if (bus.resp_valid_o != '0) cntV++;
    end
    chk("midrst no response", cntV, 0);

    // unit never answers
    unitEn = 1'b0;
    step(); setReq(0, 1'b0, 16'h4080);
`ifdef LAMP_SQRT_ARB_TIMEOUT_EN
    waitResp(200, rv, rr, re, rc);
    chk("timeout owner", rv, 2'b01);
    chk("timeout result", rr, 16'h7FC0);
    chk("timeout err", re, 1'b1);
    chk("timeout latency", rc - accCycle, 66);
`else
    cntV = 0; cntE = 0;
    for (int i = 0; i < 1000; i++) begin
      step(); @(negedge clk);
      if (bus.resp_valid_o != '0) cntV++;
      if (bus.resp_err_o) cntE++;
    end
    chk("nowd resp_valid", cntV, 0);
    chk("nowd err", cntE, 0);
    chk("nowd operand held", bus.u_operand_o, 16'h4080);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
`endif
    unitEn = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lamp_fpu_sqrt_arbiter.md
Name: lamp_fpu_sqrt_arbiter

Overview:
- Shares one square-root / inverse-square-root unit of the LAMP FPU between N_REQ requesters.
- Round-robin arbitration grants one requester at a time.
- Holds the operand stable and issues a single-cycle doSqrt/doInvSqrt pulse to the unit.
- Waits for the unit's valid, then returns the result to the granted requester over a valid/ready response channel.
- Only one operation is in flight at a time, matching the unit's non-pipelined iterative fraction core.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DW, LAMP_FLOAT_DW, width of packed float operand and result.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT state; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  N_REQ  requester has an operation pending
- req_ready_o  out  N_REQ  one-hot accept; handshake completes when valid & ready
- req_op_i  in  N_REQ  per-requester opcode: 0 = sqrt, 1 = invsqrt
- req_operand_i  in  N_REQ*DW  per-requester packed operand
- resp_valid_o  out  N_REQ  one-hot result valid for the owning requester
- resp_ready_i  in  N_REQ  requester accepts result
- resp_result_o  out  DW  result word, shared by all requesters, qualified by resp_valid_o
- resp_err_o  out  1  watchdog expiry flag, qualified by resp_valid_o
- u_doSqrt_o  out  1  start pulse to unit, sqrt
- u_doInvSqrt_o  out  1  start pulse to unit, invsqrt
- u_operand_o  out  DW  operand to unit; stable from ISSUE through WAIT
- u_valid_i  in  1  unit result valid, single-cycle
- u_result_i  in  DW  unit packed result (post-rounding)

Behaviour:
- Reset (clk, rst synchronous, active-high):
  - State returns to IDLE and the round-robin pointer to 0.
  - All outputs go to 0, including u_operand_o, resp_result_o and resp_err_o.
  - Any in-flight operation is dropped with no response.
- State machine, IDLE / ISSUE / WAIT / RESP:
  - IDLE: if any req_valid_i is set, grant the first set bit at or after the pointer, wrapping modulo N_REQ. req_ready_o[grant] is 1 combinationally in that same cycle; all others are 0. Latch operand, opcode and owner index, then go to ISSUE. If no request is valid, stay in IDLE with req_ready_o = 0.
  - ISSUE: exactly one cycle. Drive u_doSqrt_o or u_doInvSqrt_o high according to the latched opcode, with u_operand_o = latched operand. Then go to WAIT.
  - WAIT: do pulses are 0 and u_operand_o is held. On u_valid_i, capture u_result_i into the result register, clear err, and go to RESP.
  - RESP: resp_valid_o[owner] = 1 and resp_result_o = captured value, both held stable until resp_ready_i[owner]. On that handshake, set pointer = (owner+1) mod N_REQ and go to IDLE.
- req_ready_o is 0 in every state except IDLE, so there is no request accept in the same cycle as a response handshake.
- Minimum latency: accept at cycle t, pulse at t+1, unit latency L, resp_valid_o at t+2+L.
- u_valid_i is ignored outside WAIT.
- resp_ready_i on a non-owner bit is ignored.
- Requests deasserted while waiting for a grant are legal and are simply never granted.
- Mid-operation requests stay pending. Requesters must hold req_valid_i, op and operand stable until accepted.
- Only exactly one do pulse is ever high at a time.

Optional Feature:
- Macro: LAMP_SQRT_ARB_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES without u_valid_i, the result register is loaded with the canonical positive qNaN (sign 0, QNAN_E_F) and resp_err_o = 1, then the FSM goes to RESP.
  - u_valid_i arriving in the same cycle as expiry wins: the normal result is taken with err = 0.
- When undefined: the counter is absent, resp_err_o is tied 0, and WAIT lasts indefinitely.

Decomposition:
- In lampFPU_pkg:
  - typedef enum logic[1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}.
  - typedef enum logic {SQRT_OP_SQRT, SQRT_OP_INVSQRT}.
  - LAMP_FLOAT_DW, reusing the existing QNAN_E_F constant.
- One sub-module: lamp_fpu_rr_picker, a combinational round-robin first-one finder taking the request vector and pointer and returning a one-hot grant plus index. It is reusable for a future divider arbiter.

Test Plan:
- Single request, sqrt (bfloat16): requester 0 sends op 0, operand 0x4080 (4.0) → one u_doSqrt_o pulse the cycle after accept; resp_valid_o = 2'b01, resp_result_o = 0x4000 (2.0), err 0.
- Inverse sqrt: requester 1 sends op 1, operand 0x4080 → exactly one u_doInvSqrt_o pulse; resp_valid_o = 2'b10, resp_result_o = 0x3F00 (0.5).
- Simultaneous requests after reset: both requesters valid with operands 0x4180 (16.0) and 0x3F80 (1.0) → grant order 0 then 1; results 0x4080 then 0x3F80; the pointer then favours 0 again only after 1 is served.
- Backpressure: hold resp_ready_i = 0 for 10 cycles in RESP → resp_valid_o and resp_result_o stay stable; req_ready_o = 0 throughout; no second do pulse.
- Reset mid-WAIT: assert rst for 1 cycle during computation → all outputs 0 next cycle, state IDLE; a late u_valid_i is ignored and no response is produced.
- With LAMP_SQRT_ARB_TIMEOUT_EN and a model that never asserts u_valid_i: exactly 64 WAIT cycles, then resp_result_o = 0x7FC0 and resp_err_o = 1.
- Without LAMP_SQRT_ARB_TIMEOUT_EN, same stimulus: the FSM stays in WAIT for 1000 cycles and resp_err_o stays 0.
